// File: rtl/cell_pos_reader.sv
// cell_pos_reader: fetches a cell's particle count, then streams each particle position out over valid/ready
module cell_pos_reader #(
  parameter int DATA_WIDTH = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  typedef enum logic [2:0] {IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN, DONE} state_t;
  state_t state;
  logic wait_cnt, p_rd, v0, v1;
  logic [ADDR_WIDTH-1:0] next_addr, tag0, tag1;
  logic [EW-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] fifo_count, fifo_count_next;
  logic [CW+1:0] occ;
  logic push, pop, cnt_ready, issue, to_done;
  logic [ADDR_WIDTH-1:0] q_cnt, cnt, na;
  assign mem_wren = 1'b0;
  assign mem_data = '0;
  assign out_valid = fifo_count != '0;
  assign {out_pos, out_index, out_last} = fifo[rd_ptr];
  always_comb begin
    push = v1;
    pop = out_valid && out_ready;
    fifo_count_next = fifo_count + CW'(push) - CW'(pop);
    cnt_ready = state == CNT_WAIT && wait_cnt;
    q_cnt = mem_q[ADDR_WIDTH-1:0] > MAX_CNT ? MAX_CNT : mem_q[ADDR_WIDTH-1:0];
    cnt = cnt_ready ? q_cnt : particle_count;
    na = cnt_ready ? ADDR_WIDTH'(1) : next_addr;
    occ = (CW+2)'(fifo_count_next) + (CW+2)'(p_rd) + (CW+2)'(v0);
    issue = (state == STREAM || (cnt_ready && q_cnt != '0)) && na <= cnt && occ < (CW+2)'(FIFO_DEPTH);
    to_done = (cnt_ready && q_cnt == '0) ||
              (state == DRAIN && !p_rd && !v0 && !v1 && fifo_count_next == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wait_cnt <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      mem_rden <= 1'b0;
      mem_address <= '0;
      particle_count <= '0;
      next_addr <= '0;
      p_rd <= 1'b0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      tag0 <= '0;
      tag1 <= '0;
    end else begin
      mem_rden <= issue || (state == IDLE && start);
      p_rd <= issue;
      v0 <= p_rd;
      v1 <= v0;
      tag0 <= mem_address;
      tag1 <= tag0;
      done <= to_done;
      if (issue) begin
        mem_address <= na;
        next_addr <= na + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          state <= CNT_REQ;
          busy <= 1'b1;
          mem_address <= '0;
        end
        CNT_REQ: begin
          state <= CNT_WAIT;
          wait_cnt <= 1'b0;
        end
        CNT_WAIT: begin
          wait_cnt <= 1'b1;
          if (wait_cnt) begin
            particle_count <= q_cnt;
            state <= q_cnt == '0 ? DONE : (issue && na == cnt) ? DRAIN : STREAM;
          end
        end
        STREAM: if (issue && na == cnt) state <= DRAIN;
        DRAIN: if (to_done) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (to_done) busy <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        assert (fifo_count != CW'(FIFO_DEPTH));
        fifo[wr_ptr] <= {mem_q, tag1, tag1 == particle_count};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count_next;
    end
  end
endmodule

// File: doc/cell_pos_reader.md
Name: cell_pos_reader

Overview:
- Read-side sequencer for one per-cell position memory: single-port, 2-cycle read latency, address 0 = particle count, addresses 1..N = {posz, posy, posx}.
- On start, fetches the count, then streams every particle position out over a valid/ready interface.
- Sits between a cell position RAM and the force-evaluation / motion-update consumers.
- A 4-entry output FIFO with credit-based read issue absorbs RAM latency under backpressure.

Parameters:
DATA_WIDTH, 96, position word width {posz, posy, posx}, 32 bits each
PARTICLE_NUM, 220, RAM depth (count word + particles)
ADDR_WIDTH, 8, RAM address width
FIFO_DEPTH, 4, output buffer entries (power of 2, ≥3)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse to begin a cell scan
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse after last particle is handed off
particle_count  out  ADDR_WIDTH  count latched from address 0 (after clamp)
mem_address  out  ADDR_WIDTH  RAM address
mem_rden  out  1  RAM read enable
mem_wren  out  1  RAM write enable, constant 0
mem_data  out  DATA_WIDTH  RAM write data, constant 0
mem_q  in  DATA_WIDTH  RAM read data, valid 2 cycles after rden
out_valid  out  1  out_pos holds a particle
out_ready  in  1  consumer accepts when valid&&ready
out_pos  out  DATA_WIDTH  particle position {posz, posy, posx}
out_index  out  ADDR_WIDTH  RAM address of the particle (1..N)
out_last  out  1  marks particle N

Behaviour:
- Reset values:
  - busy, done, mem_rden, out_valid, out_last = 0.
  - mem_address, particle_count, out_index, out_pos = 0.
  - FIFO empty; in-flight tracker cleared; state IDLE.
- Reset mid-scan aborts the scan. Read data returning after reset is discarded.
- FSM states: IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 → CNT_REQ.
  - start while not IDLE is ignored.
- CNT_REQ (1 cycle):
  - mem_address=0, mem_rden=1, busy=1.
  - → CNT_WAIT.
- CNT_WAIT (2 cycles):
  - Second cycle: particle_count = min(mem_q[ADDR_WIDTH-1:0], PARTICLE_NUM-1).
  - count==0 → DONE; else → STREAM, with next_addr=1.
- STREAM:
  - Issue read (mem_rden=1, mem_address=next_addr, next_addr++) when fifo_count + inflight < FIFO_DEPTH.
  - inflight = number of reads issued in the last 2 cycles (2-bit valid shift register). A tag shift register carries the address alongside each read.
  - When next_addr would exceed count, stop issuing → DRAIN.
- DRAIN: wait until inflight==0 and the FIFO is empty → DONE.
- DONE: done=1 for 1 cycle, busy=0 → IDLE.
- FIFO write:
  - Occurs when the valid shift register output is 1.
  - Entry = {mem_q, tag, tag==count}.
  - Credit rule guarantees no overflow. A write into a full FIFO is an assertion failure.
- FIFO read: on out_valid && out_ready.
- out_* are driven from the FIFO head. Each is stable while out_valid && !out_ready.
- Simultaneous FIFO push and pop in one cycle: occupancy unchanged.
- Timing (start at cycle 0, out_ready held 1):
  - Count read issued cycle 1; count available cycle 3.
  - Particle 1 read cycle 4.
  - First out_valid cycle 7, then 1 particle per cycle.
  - done at cycle 7+N.
- out_ready=0: at most FIFO_DEPTH reads outstanding. Issue resumes the cycle after a pop frees a credit.
- mem_wren never asserted.

Test Plan:
1. Count=3, positions at addresses 1..3 = 0x…01/02/03, out_ready=1, start at cycle 0:
   - mem_rden at cycles 1, 4, 5, 6.
   - out_valid cycles 7–9 with out_index 1, 2, 3; out_last only at index 3.
   - done at cycle 10; busy 1..9.
2. Count=0 → no particle reads, out_valid never 1, done at cycle 4, particle_count=0.
3. Count=10, out_ready=0 from cycle 0 to cycle 20:
   - Exactly 4 particle reads issued; out_pos/out_index frozen at index 1.
   - Release ready → all 10 delivered in order, no loss or duplication.
4. Count=219, out_ready randomly toggled 50%:
   - Scoreboard indices 1..219 in order with matching data.
   - out_last once; done once; mem_wren always 0.
5. Count word 0xFF (255, above 219) → particle_count=219, last out_index=219.
6. rst asserted for 1 cycle while 2 reads are in flight in STREAM:
   - Next cycle all outputs at reset values; returning data is not pushed.
   - A new start gives a clean full scan.
